// File: rtl/serial_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_full_adder
// Purpose  : Bit-serial WIDTH-bit adder. One full-adder cell plus a carry
//            flip-flop computes {carry_out_o, sum_o} = a_i + b_i + carry_in_i,
//            one bit per clock, LSB first, behind a start/busy/done handshake.
// Ports    : clk_i           - clock, rising edge
//            rst_ni          - asynchronous active-low reset
//            start_i         - request a new addition (sampled only in IDLE)
//            a_i, b_i        - operands, captured on the accepting edge
//            carry_in_i      - initial carry, captured on the accepting edge
//            busy_o          - operation in progress (RUN or DONE)
//            sum_bit_o       - serial sum bit for the current RUN cycle
//            sum_bit_valid_o - qualifies sum_bit_o
//            done_o          - one-cycle pulse, sum_o/carry_out_o newly valid
//            sum_o           - parallel result, held until the next DONE
//            carry_out_o     - final carry out, held until the next DONE
// Revision : 1.0 - initial release
// ============================================================================
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_in_i,
  output logic             busy_o,
  output logic             sum_bit_o,
  output logic             sum_bit_valid_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Full-adder cell on the current LSBs and the carry flip-flop.
  logic fa_sum;
  logic fa_carry;
  assign fa_sum   = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_carry = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  // Status outputs decode the registered state only, so start_i cannot
  // glitch them. sum_bit_o is forced low outside RUN.
  assign busy_o          = (state_q != S_IDLE);
  assign sum_bit_valid_o = (state_q == S_RUN);
  assign done_o          = (state_q == S_DONE);
  assign sum_bit_o       = (state_q == S_RUN) & fa_sum;
  assign sum_o           = sum_q;
  assign carry_out_o     = cout_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          c_d     = carry_in_i;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Sum bits enter at the MSB so that after WIDTH shifts the first
        // (LSB) bit has reached position 0.
        res_d = {fa_sum, res_q[WIDTH-1:1]};
        c_d   = fa_carry;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Publish on the final RUN edge so the result is already valid
          // during the DONE cycle.
          sum_d   = res_d;
          cout_d  = fa_carry;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire
